// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt handler unit.
// State encoding, cause codes and the default handler vector.
package irq_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ENTER   = 2'd1,
        HANDLER = 2'd2,
        EXIT    = 2'd3
    } irq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_TIMER = 2'd1,
        CAUSE_IO    = 2'd2
    } cause_t;

    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'd64;

    localparam int GRANT_TMR = 0;
    localparam int GRANT_IO  = 1;

endpackage

// File: rtl/interrupt_handler_unit_if.sv
// CPU-side bundle of the interrupt handler unit.
// master = processor pipeline, slave = interrupt handler unit.
interface interrupt_handler_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                int_enable;
    logic                instr_boundary;
    logic [PC_WIDTH-1:0] pc_current;
    logic                rfi;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_target;
    logic [PC_WIDTH-1:0] epc;
    logic [1:0]          cause;
    logic                in_handler;

    modport master (
        output int_enable,
        output instr_boundary,
        output pc_current,
        output rfi,
        input  pc_load,
        input  pc_target,
        input  epc,
        input  cause,
        input  in_handler
    );

    modport slave (
        input  int_enable,
        input  instr_boundary,
        input  pc_current,
        input  rfi,
        output pc_load,
        output pc_target,
        output epc,
        output cause,
        output in_handler
    );

endinterface

// File: rtl/irq_priority_select.sv
// Fixed-priority arbiter between pending interrupt sources.
// Timer wins over I/O; grant is one-hot and used to clear the winner.
module irq_priority_select
    import irq_pkg::*;
(
    input  logic       pend_tmr,
    input  logic       pend_io,
    output logic [1:0] grant,
    output cause_t     code
);

    always_comb begin
        grant = 2'b00;
        code  = CAUSE_NONE;
        if (pend_tmr) begin
            grant[GRANT_TMR] = 1'b1;
            code             = CAUSE_TIMER;
        end else if (pend_io) begin
            grant[GRANT_IO] = 1'b1;
            code            = CAUSE_IO;
        end
    end

endmodule

// File: rtl/interrupt_handler_unit.sv
// Interrupt entry/exit sequencer between the preemption timer and PC select.
// Define IO_INTERRUPT_EN to add the io_int request source (cause 2).
module interrupt_handler_unit
    import irq_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] HANDLER_ADDR =
        PC_WIDTH'(HANDLER_ADDR_DEFAULT)
) (
    input  logic clock,
    input  logic reset,
    input  logic sigint,
`ifdef IO_INTERRUPT_EN
    input  logic io_int,
`endif
    interrupt_handler_unit_if.slave cpu,
    output logic timer_stop,
    output logic timer_reset
);

    irq_state_t          state_q;
    irq_state_t          state_d;
    logic                pend_tmr_q;
    logic                pend_io_q;
    logic [PC_WIDTH-1:0] epc_q;
    cause_t              cause_q;
    logic                take;
    logic [1:0]          grant;
    logic [1:0]          grant_eff;
    cause_t              sel_code;
    logic                tmr_req;
    logic                io_req;

    // Timer requests are only heard in RUN: once stopped it may lag one edge.
    assign tmr_req = sigint && (state_q == RUN);

`ifdef IO_INTERRUPT_EN
    assign io_req = io_int;
`else
    assign io_req = 1'b0;
`endif

    irq_priority_select u_sel (
        .pend_tmr (pend_tmr_q),
        .pend_io  (pend_io_q),
        .grant    (grant),
        .code     (sel_code)
    );

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            RUN: begin
                if ((pend_tmr_q || pend_io_q) &&
                    cpu.int_enable && cpu.instr_boundary) begin
                    take    = 1'b1;
                    state_d = ENTER;
                end
            end
            ENTER: begin
                state_d = HANDLER;
            end
            HANDLER: begin
                if (cpu.rfi && cpu.instr_boundary) begin
                    state_d = EXIT;
                end
            end
            EXIT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign grant_eff = take ? grant : 2'b00;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            pend_tmr_q <= 1'b0;
            pend_io_q  <= 1'b0;
            epc_q      <= '0;
            cause_q    <= CAUSE_NONE;
        end else begin
            state_q    <= state_d;
            // A grant consumes the request even if the line is still high.
            pend_tmr_q <= (pend_tmr_q | tmr_req) & ~grant_eff[GRANT_TMR];
            pend_io_q  <= (pend_io_q | io_req) & ~grant_eff[GRANT_IO];
            if (take) begin
                epc_q   <= cpu.pc_current;
                cause_q <= sel_code;
            end
            if (state_q == EXIT) begin
                cause_q <= CAUSE_NONE;
            end
        end
    end

    always_comb begin
        cpu.pc_target = '0;
        unique case (state_q)
            ENTER:   cpu.pc_target = HANDLER_ADDR;
            EXIT:    cpu.pc_target = epc_q;
            default: cpu.pc_target = '0;
        endcase
    end

    assign cpu.pc_load    = (state_q == ENTER) || (state_q == EXIT);
    assign cpu.in_handler = (state_q == ENTER) || (state_q == HANDLER);
    assign cpu.epc        = epc_q;
    assign cpu.cause      = cause_q;
    assign timer_stop     = cpu.in_handler;
    assign timer_reset    = (state_q == EXIT);

endmodule

// File: tb/tb_interrupt_handler_unit.sv
// Scoreboard bench for interrupt_handler_unit.
// Redirect expectations are queued by stimulus and checked by a monitor.
module tb_interrupt_handler_unit;

    logic clock = 1'b0;
    logic reset;
    logic sigint;
    logic io_int;
    logic timer_stop;
    logic timer_reset;

    interrupt_handler_unit_if #(.PC_WIDTH(32)) cpu ();

    interrupt_handler_unit #(
        .PC_WIDTH     (32),
        .HANDLER_ADDR (32'd64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sigint      (sigint),
`ifdef IO_INTERRUPT_EN
        .io_int      (io_int),
`endif
        .cpu         (cpu),
        .timer_stop  (timer_stop),
        .timer_reset (timer_reset)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        trst;
        logic        tstop;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always @(negedge clock) begin
        if (!reset && cpu.pc_load) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_redirect got tgt=%h required no pc_load",
                         cpu.pc_target);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cpu.pc_target !== e.tgt || cpu.epc !== e.epc ||
                    cpu.cause !== e.cause || timer_reset !== e.trst ||
                    timer_stop !== e.tstop) begin
                    miscompares++;
                    $display("FAIL redirect got tgt=%h epc=%h cause=%0d trst=%b tstop=%b required tgt=%h epc=%h cause=%0d trst=%b tstop=%b",
                             cpu.pc_target, cpu.epc, cpu.cause, timer_reset,
                             timer_stop, e.tgt, e.epc, e.cause, e.trst, e.tstop);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got %h required %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [31:0] tgt, input logic [31:0] epc,
                        input logic [1:0] cause, input logic trst,
                        input logic tstop);
        exp_t e;
        e.tgt   = tgt;
        e.epc   = epc;
        e.cause = cause;
        e.trst  = trst;
        e.tstop = tstop;
        q.push_back(e);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_pc_load"}, {31'd0, cpu.pc_load}, 32'd0);
        chk({nm, "_pc_target"}, cpu.pc_target, 32'd0);
        chk({nm, "_epc"}, cpu.epc, 32'd0);
        chk({nm, "_cause"}, {30'd0, cpu.cause}, 32'd0);
        chk({nm, "_timer_stop"}, {31'd0, timer_stop}, 32'd0);
        chk({nm, "_timer_reset"}, {31'd0, timer_reset}, 32'd0);
        chk({nm, "_in_handler"}, {31'd0, cpu.in_handler}, 32'd0);
    endtask

    task automatic wait_handler(input string nm);
        int n = 0;
        while (!cpu.in_handler && n < 20) begin
            tick;
            n++;
        end
        chk({nm, "_enter_timeout"}, {31'd0, cpu.in_handler}, 32'd1);
    endtask

    task automatic do_rfi(input logic [31:0] ret, input logic [1:0] cause);
        push(ret, ret, cause, 1'b1, 1'b0);
        cpu.rfi            = 1'b1;
        cpu.instr_boundary = 1'b1;
        tick;
        cpu.rfi = 1'b0;
        chk("exit_timer_reset", {31'd0, timer_reset}, 32'd1);
        chk("exit_timer_stop", {31'd0, timer_stop}, 32'd0);
        chk("exit_target", cpu.pc_target, ret);
        tick;
        chk("run_in_handler", {31'd0, cpu.in_handler}, 32'd0);
        chk("run_cause", {30'd0, cpu.cause}, 32'd0);
        chk("run_pc_load", {31'd0, cpu.pc_load}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        sigint             = 1'b0;
        io_int             = 1'b0;
        cpu.int_enable     = 1'b0;
        cpu.instr_boundary = 1'b0;
        cpu.pc_current     = 32'd0;
        cpu.rfi            = 1'b0;
        repeat (3) tick;
        chk_idle("reset");
        reset = 1'b0;

        // Basic timer entry with latency check
        cpu.int_enable     = 1'b1;
        cpu.instr_boundary = 1'b1;
        cpu.pc_current     = 32'h200;
        push(32'd64, 32'h200, 2'd1, 1'b0, 1'b1);
        sigint = 1'b1;
        tick;
        sigint = 1'b0;
        chk("latency_latch_edge", {31'd0, cpu.pc_load}, 32'd0);
        tick;
        chk("latency_enter", {31'd0, cpu.pc_load}, 32'd1);
        chk("enter_epc", cpu.epc, 32'h200);
        chk("enter_stop", {31'd0, timer_stop}, 32'd1);
        tick;
        chk("handler_stop", {31'd0, timer_stop}, 32'd1);
        chk("handler_in", {31'd0, cpu.in_handler}, 32'd1);
        chk("handler_target", cpu.pc_target, 32'd0);
        chk("handler_cause", {30'd0, cpu.cause}, 32'd1);
        // Late sigint while stopped must not be latched
        sigint = 1'b1;
        tick;
        tick;
        sigint         = 1'b0;
        cpu.pc_current = 32'h480;
        repeat (3) tick;
        do_rfi(32'h200, 2'd1);
        repeat (5) tick;
        chk("no_relatch", {31'd0, cpu.in_handler}, 32'd0);

        // rfi in RUN is ignored
        cpu.rfi = 1'b1;
        repeat (3) tick;
        cpu.rfi = 1'b0;
        chk("rfi_run_in_handler", {31'd0, cpu.in_handler}, 32'd0);
        chk("rfi_run_timer_reset", {31'd0, timer_reset}, 32'd0);

        // Pending held while disabled
        cpu.int_enable = 1'b0;
        sigint = 1'b1;
        tick;
        sigint = 1'b0;
        repeat (10) tick;
        chk("disabled_no_entry", {31'd0, cpu.in_handler}, 32'd0);
        cpu.pc_current     = 32'h300;
        cpu.instr_boundary = 1'b0;
        cpu.int_enable     = 1'b1;
        tick;
        tick;
        chk("no_boundary_no_entry", {31'd0, cpu.in_handler}, 32'd0);
        push(32'd64, 32'h300, 2'd1, 1'b0, 1'b1);
        cpu.instr_boundary = 1'b1;
        tick;
        chk("enable_enter", {31'd0, cpu.pc_load}, 32'd1);
        chk("enable_cause", {30'd0, cpu.cause}, 32'd1);
        tick;
        do_rfi(32'h300, 2'd1);

        // Reset while in HANDLER
        push(32'd64, 32'h300, 2'd1, 1'b0, 1'b1);
        sigint = 1'b1;
        tick;
        sigint = 1'b0;
        wait_handler("rst_mid");
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk_idle("rst_mid");

        // Reset clears a pending request
        cpu.int_enable = 1'b0;
        sigint = 1'b1;
        tick;
        sigint = 1'b0;
        reset  = 1'b1;
        tick;
        reset = 1'b0;
        cpu.int_enable = 1'b1;
        repeat (5) tick;
        chk("rst_clears_pend", {31'd0, cpu.in_handler}, 32'd0);

`ifdef IO_INTERRUPT_EN
        // Timer beats I/O, I/O follows after return
        cpu.pc_current = 32'h500;
        push(32'd64, 32'h500, 2'd1, 1'b0, 1'b1);
        sigint = 1'b1;
        io_int = 1'b1;
        tick;
        sigint = 1'b0;
        io_int = 1'b0;
        tick;
        chk("prio_timer_first", {30'd0, cpu.cause}, 32'd1);
        tick;
        push(32'h500, 32'h500, 2'd1, 1'b1, 1'b0);
        push(32'd64, 32'h500, 2'd2, 1'b0, 1'b1);
        cpu.rfi = 1'b1;
        tick;
        cpu.rfi = 1'b0;
        tick;
        tick;
        chk("prio_io_second", {30'd0, cpu.cause}, 32'd2);
        tick;
        do_rfi(32'h500, 2'd2);
`endif

        repeat (3) tick;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interrupt_handler_unit.md
# interrupt_handler_unit

Consumer side of the preemption timer's `sigint` line. It latches interrupt requests and waits for an instruction boundary with interrupts enabled. It then saves the return PC, redirects the processor to the OS handler vector and holds the timer stopped while the handler runs. On return-from-interrupt it restores the PC and restarts the timer's quantum. It sits between the timer (and optionally I/O) and the processor's PC-select logic.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC values
- HANDLER_ADDR, 32'd64, handler entry vector (PC_WIDTH bits)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- sigint  in  1  timer interrupt request (level)
- io_int  in  1  I/O interrupt request (level); present only with IO_INTERRUPT_EN
- int_enable  in  1  global interrupt enable from the status register
- instr_boundary  in  1  current instruction retires this cycle; safe point
- pc_current  in  PC_WIDTH  PC of next instruction to execute (return address)
- rfi  in  1  return-from-interrupt instruction retiring (valid only with instr_boundary)
- pc_load  out  1  one-cycle pulse; CPU must load pc_target next edge
- pc_target  out  PC_WIDTH  redirect address
- epc  out  PC_WIDTH  saved return PC
- cause  out  2  0 none, 1 timer, 2 I/O
- timer_stop  out  1  level; drives timer `stop`
- timer_reset  out  1  one-cycle pulse; drives timer `reset`
- in_handler  out  1  high in ENTER and HANDLER

## Operation
- Pending bits pend_tmr and pend_io.
  - Set on any edge where the request input is 1.
  - sigint is sampled only in RUN; io_int is sampled in all states.
- State machine (RUN, ENTER, HANDLER, EXIT):
  - RUN: if (pend_tmr|pend_io) && int_enable && instr_boundary, then capture epc<=pc_current, set cause, clear the selected pending bit, and go to ENTER. rfi is ignored in RUN.
  - ENTER: pc_load=1, pc_target=HANDLER_ADDR, timer_stop=1. Always goes to HANDLER next.
  - HANDLER: timer_stop=1. If rfi && instr_boundary, go to EXIT. No nested interrupts are taken.
  - EXIT: pc_load=1, pc_target=epc, timer_reset=1, timer_stop=0, cause<=0. Always goes to RUN next.
- Priority: timer > I/O. The losing request stays pending and is taken at the next eligible boundary in RUN.
- int_enable low: pending bits are held and never dropped.
- pc_target is 0 whenever pc_load=0.

## Timing
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- Reset value: state=RUN; pend_*=0; epc=0; cause=0; pc_load, pc_target, timer_stop, timer_reset and in_handler all 0.
- Request latency: sigint high at edge N sets pending at N. The earliest entry decision is at edge N+1, with pc_load high during cycle N+2.
- Entry: boundary decision at edge K. ENTER (pc_load) is in cycle K+1 and HANDLER starts in cycle K+2.
- Exit: rfi decision at edge M. EXIT (pc_load, timer_reset) is in cycle M+1 and RUN starts in cycle M+2.
- Reset mid-handler: returns to RUN immediately with all outputs zero. timer_reset is not pulsed; the system reset covers the timer.
- sigint still high during ENTER/HANDLER (timer stop takes one edge) is ignored and never re-latched.
- io_int and the boundary decision on the same edge: the newly latched bit is not eligible until the next edge.

## Configuration
- IO_INTERRUPT_EN defined:
  - io_int port exists.
  - pend_io is active with the priority rules above.
  - cause=2 is reachable.
- IO_INTERRUPT_EN undefined:
  - No io_int port.
  - pend_io is tied 0.
  - cause is only ever 0 or 1.

## Structure
- Shared package `irq_pkg`:
  - state enum (RUN, ENTER, HANDLER, EXIT)
  - cause codes CAUSE_NONE=0, CAUSE_TIMER=1, CAUSE_IO=2
  - default HANDLER_ADDR constant
- One sub-module, `irq_priority_select`: takes pend_tmr and pend_io; returns the grant (one-hot clear) and the cause code.

## Test plan
- Reset, then sigint=1 at cycle 3, int_enable=1, instr_boundary every cycle, pc_current=0x200 → pc_load with pc_target=64 in cycle 5; epc=0x200; cause=1; timer_stop high from cycle 5.
- In HANDLER, assert rfi+instr_boundary at cycle 20 → cycle 21 has pc_load, pc_target=0x200, timer_reset=1, timer_stop=0; RUN from cycle 22.
- int_enable=0 with sigint pulsed for one cycle, enable raised 10 cycles later → handler entered at the first boundary after enable; cause=1.
- IO_INTERRUPT_EN: sigint and io_int high on the same cycle → timer serviced first (cause=1). After rfi, I/O is serviced at the next boundary (cause=2).
- Reset asserted while in HANDLER → next cycle RUN; every output 0; pending bits cleared.
- rfi asserted in RUN → no pc_load and no state change.
